borrow_lookahead_sub: RTL

BORROW_LOOKAHEAD_SUB -- requirements
Module: borrow_lookahead_sub

---
 rtl/borrow_lookahead_sub.sv | 137 +++++++++++++
 1 files changed

// File: rtl/borrow_lookahead_sub.sv
// Multi-cycle wide subtractor: one LIMB_WIDTH slice per cycle, LSB limb first,
// each limb built from chained 4-bit borrow-lookahead groups.
module borrow_lookahead_sub #(
    parameter int OPERAND_WIDTH = 256,
    parameter int LIMB_WIDTH    = 64
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic [OPERAND_WIDTH-1:0] iA,
    input  logic [OPERAND_WIDTH-1:0] iB,
    input  logic                     iBorrow,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [OPERAND_WIDTH-1:0] oDiff,
    output logic                     oBorrow
);

    localparam int NLIMB  = OPERAND_WIDTH / LIMB_WIDTH;
    localparam int CNT_W  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam int NGROUP = LIMB_WIDTH / 4;
    localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(NLIMB - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [CNT_W-1:0]         limb_cnt_q;
    logic [OPERAND_WIDTH-1:0] a_q;
    logic [OPERAND_WIDTH-1:0] b_q;
    logic [OPERAND_WIDTH-1:0] diff_q;
    logic                     borrow_q;
    logic [LIMB_WIDTH-1:0]    limb_a;
    logic [LIMB_WIDTH-1:0]    limb_b;
    logic [LIMB_WIDTH-1:0]    limb_diff;
    logic                     limb_bout;

    // Returns {borrow_out, diff[3:0]}; every internal borrow is a flat sum of products.
    function automatic logic [4:0] group_sub(input logic [3:0] a, input logic [3:0] b,
                                             input logic bin);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] bb;
        logic       bout;
        g     = ~a & b;
        p     = ~(a ^ b);
        bb[0] = bin;
        bb[1] = g[0] | (p[0] & bin);
        bb[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
        bb[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
        bout  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (&p & bin);
        return {bout, a ^ b ^ bb};
    endfunction

    function automatic logic [LIMB_WIDTH:0] limb_sub(input logic [LIMB_WIDTH-1:0] a,
                                                     input logic [LIMB_WIDTH-1:0] b,
                                                     input logic bin);
        logic [LIMB_WIDTH-1:0] d;
        logic                  c;
        logic [4:0]            r;
        c = bin;
        d = '0;
        for (int gi = 0; gi < NGROUP; gi++) begin
            r            = group_sub(a[gi*4 +: 4], b[gi*4 +: 4], c);
            d[gi*4 +: 4] = r[3:0];
            c            = r[4];
        end
        return {c, d};
    endfunction

    always_comb begin
        limb_a = a_q[int'(limb_cnt_q)*LIMB_WIDTH +: LIMB_WIDTH];
        limb_b = b_q[int'(limb_cnt_q)*LIMB_WIDTH +: LIMB_WIDTH];
        {limb_bout, limb_diff} = limb_sub(limb_a, limb_b, borrow_q);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iValid) state_d = CALC;
            CALC:    if (limb_cnt_q == LAST_LIMB) state_d = DONE;
            DONE:    if (iReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are only read during CALC, so they need no reset.
    always_ff @(posedge iClk) begin
        if (state_q == IDLE && iValid) begin
            a_q <= iA;
            b_q <= iB;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            limb_cnt_q <= '0;
            borrow_q   <= 1'b0;
            diff_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iValid) begin
                        borrow_q   <= iBorrow;
                        limb_cnt_q <= '0;
                    end
                end
                CALC: begin
                    diff_q[int'(limb_cnt_q)*LIMB_WIDTH +: LIMB_WIDTH] <= limb_diff;
                    borrow_q   <= limb_bout;
                    limb_cnt_q <= limb_cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign oReady  = (state_q == IDLE);
    assign oValid  = (state_q == DONE);
    assign oDiff   = diff_q;
    assign oBorrow = borrow_q;

endmodule
